// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: turns a solved knight's tour into motion commands.
// It sits between the UART command path and the command processor.
// When no tour is running, UART commands pass straight through.
// During a replay, each of the 24 moves becomes a vertical command
// followed by a horizontal command, each waiting for its own
// consume/complete handshake.
//
// state  | meaning
// IDLE   | UART pass-through; waiting for start_tour
// VERT   | offering the vertical leg of move mv_indx
// WAIT_V | vertical leg consumed; waiting for it to finish executing
// HORZ   | offering the horizontal leg of move mv_indx
// WAIT_H | horizontal leg consumed; waiting for it to finish executing
module tour_cmd_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_tour,
    input  logic [7:0]  move,
    output logic [4:0]  mv_indx,
    input  logic [15:0] cmd_UART,
    input  logic        cmd_rdy_UART,
    output logic        clr_cmd_rdy_UART,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic [7:0]  resp
);

    typedef enum logic [2:0] {IDLE, VERT, WAIT_V, HORZ, WAIT_H} state_t;

    localparam logic [4:0] LAST_MOVE = 5'd23;
    localparam logic [7:0] RESP_DONE = 8'hA5;
    localparam logic [7:0] RESP_BUSY = 8'h5A;

    state_t            state_q, state_d;
    logic [4:0]        mv_indx_q, mv_indx_d;
    logic signed [2:0] dx, dy;
    logic [2:0]        dx_mag, dy_mag;
    logic [15:0]       vert_cmd, horz_cmd;

    // Decode the move word into (dx,dy); the lowest set bit wins, and no set bit means no motion.
    always_comb begin
        dx = 3'sd0;
        dy = 3'sd0;
        casez (move)
            8'b???????1: begin dx = -3'sd1; dy =  3'sd2; end
            8'b??????10: begin dx =  3'sd1; dy =  3'sd2; end
            8'b?????100: begin dx = -3'sd2; dy =  3'sd1; end
            8'b????1000: begin dx = -3'sd2; dy = -3'sd1; end
            8'b???10000: begin dx = -3'sd1; dy = -3'sd2; end
            8'b??100000: begin dx =  3'sd1; dy = -3'sd2; end
            8'b?1000000: begin dx =  3'sd2; dy = -3'sd1; end
            8'b10000000: begin dx =  3'sd2; dy =  3'sd1; end
            default:     begin dx =  3'sd0; dy =  3'sd0; end
        endcase
    end

    // Build the two command words: vertical as a plain move, horizontal as a move with fanfare.
    always_comb begin
        dx_mag   = dx[2] ? 3'(-dx) : 3'(dx);
        dy_mag   = dy[2] ? 3'(-dy) : 3'(dy);
        vert_cmd = {4'h2, (dy[2] ? 8'h7F : 8'h00), 1'b0, dy_mag};
        horz_cmd = {4'h3, (dx[2] ? 8'h3F : ((dx != 3'sd0) ? 8'hBF : 8'h00)), 1'b0, dx_mag};
    end

    // State and move-index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mv_indx_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    // Next-state logic and output muxing between UART pass-through and the sequencer.
    always_comb begin
        state_d          = state_q;
        mv_indx_d        = mv_indx_q;
        cmd              = vert_cmd;
        cmd_rdy          = 1'b0;
        clr_cmd_rdy_UART = 1'b0;
        resp             = RESP_BUSY;
        case (state_q)
            IDLE: begin
                cmd              = cmd_UART;
                cmd_rdy          = cmd_rdy_UART;
                clr_cmd_rdy_UART = clr_cmd_rdy;
                resp             = RESP_DONE;
                if (start_tour) begin
                    mv_indx_d = 5'd0;
                    state_d   = VERT;
                end
            end
            VERT: begin
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_d = WAIT_V;
            end
            WAIT_V: begin
                if (send_resp) state_d = HORZ;
            end
            HORZ: begin
                cmd     = horz_cmd;
                cmd_rdy = 1'b1;
                if (clr_cmd_rdy) state_d = WAIT_H;
            end
            WAIT_H: begin
                cmd = horz_cmd;
                if (mv_indx_q == LAST_MOVE) resp = RESP_DONE;
                if (send_resp) begin
                    if (mv_indx_q == LAST_MOVE) begin
                        state_d = IDLE;
                    end else begin
                        mv_indx_d = mv_indx_q + 5'd1;
                        state_d   = VERT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mv_indx = mv_indx_q;

endmodule
